// File: rtl/xif_sched_pkg.sv
// rtl/xif_sched_pkg.sv - shared opcode, funct3 and multiplier-state types for xif_scheduler
package xif_sched_pkg;

  localparam logic [6:0] OPCODE_XIF = 7'h5B;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2
  } xif_op_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/xif_mul_iter.sv
// rtl/xif_mul_iter.sv - iterative shift-add multiplier, one step per cycle, low-word product
module xif_mul_iter
  import xif_sched_pkg::*;
#(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        busy_o,
  output logic        last_o,
  output logic [31:0] product_o
);

  localparam int CNT_W = $clog2(MUL_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  mul_state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] partial_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start_i) state_d = MUL_BUSY;
      MUL_BUSY: if (count_q == CNT_LAST) state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == MUL_BUSY);
    last_o = busy_o && (count_q == CNT_LAST);
  end

  // product_o is the accumulator after the current step; the top samples it on last_o
  always_comb begin
    partial_sum = mplier_q[0] ? mcand_q : 32'd0;
    product_o   = acc_q + partial_sum;
    count_d     = count_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    if (start_i && !busy_o) begin
      count_d  = '0;
      acc_d    = 32'd0;
      mcand_d  = op_a_i;
      mplier_d = op_b_i;
    end else if (busy_o) begin
      count_d  = count_q + 1'b1;
      acc_d    = product_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
    end else begin
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/xif_scheduler.sv
// rtl/xif_scheduler.sv - decodes custom R-type ops, runs ALU/multiplier, shares one result port
module xif_scheduler
  import xif_sched_pkg::*;
#(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid_i,
  input  logic [31:0] issue_instr_i,
  input  logic [31:0] issue_op0_i,
  input  logic [31:0] issue_op1_i,
  input  logic [3:0]  issue_id_i,
  output logic        issue_ready_o,
  output logic        issue_accept_o,
  output logic        result_valid_o,
  output logic [3:0]  result_id_o,
  output logic [4:0]  result_rd_o,
  output logic [31:0] result_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic        unused_instr;
  logic        is_mul;
  logic        fire;
  logic        alu_fire;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_last;
  logic [31:0] mul_product;
  logic [31:0] alu_result;

  logic [3:0]  mul_id_q, mul_id_d;
  logic [4:0]  mul_rd_q, mul_rd_d;
  logic        res_valid_q, res_valid_d;
  logic [3:0]  res_id_q, res_id_d;
  logic [4:0]  res_rd_q, res_rd_d;
  logic [31:0] res_data_q, res_data_d;

  assign opcode       = issue_instr_i[6:0];
  assign rd           = issue_instr_i[11:7];
  assign funct3       = issue_instr_i[14:12];
  assign funct7       = issue_instr_i[31:25];
  assign unused_instr = ^issue_instr_i[24:15];

  always_comb begin
    is_mul         = (funct3 == OP_MUL);
    issue_accept_o = (opcode == OPCODE_XIF) && (funct7 == 7'd0) &&
                     ((funct3 == OP_ADD) || (funct3 == OP_SUB) || (funct3 == OP_MUL));
    // the last multiply step owns the next result slot, so nothing may issue then
    issue_ready_o  = !(mul_busy && ((issue_accept_o && is_mul) || mul_last));
    fire           = issue_valid_i && issue_ready_o && issue_accept_o;
    alu_fire       = fire && !is_mul;
    mul_start      = fire && is_mul;
    alu_result     = (funct3 == OP_SUB) ? (issue_op0_i - issue_op1_i)
                                        : (issue_op0_i + issue_op1_i);
  end

  xif_mul_iter #(
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .op_a_i    (issue_op0_i),
    .op_b_i    (issue_op1_i),
    .busy_o    (mul_busy),
    .last_o    (mul_last),
    .product_o (mul_product)
  );

  always_comb begin
    mul_id_d    = mul_id_q;
    mul_rd_d    = mul_rd_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    if (mul_start) begin
      mul_id_d = issue_id_i;
      mul_rd_d = rd;
    end
    if (mul_last) begin
      res_valid_d = 1'b1;
      res_id_d    = mul_id_q;
      res_rd_d    = mul_rd_q;
      res_data_d  = mul_product;
    end else if (alu_fire) begin
      res_valid_d = 1'b1;
      res_id_d    = issue_id_i;
      res_rd_d    = rd;
      res_data_d  = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_id_q    <= 4'd0;
      mul_rd_q    <= 5'd0;
      res_valid_q <= 1'b0;
      res_id_q    <= 4'd0;
      res_rd_q    <= 5'd0;
      res_data_q  <= 32'd0;
    end else begin
      mul_id_q    <= mul_id_d;
      mul_rd_q    <= mul_rd_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
    end
  end

  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_o       = res_data_q;

endmodule

// File: tb/tb_xif_scheduler.sv
// tb/tb_xif_scheduler.sv - directed bench with a cycle-level result-slot model for xif_scheduler
module tb_xif_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic [31:0] issue_instr_i = 32'd0;
  logic [31:0] issue_op0_i = 32'd0;
  logic [31:0] issue_op1_i = 32'd0;
  logic [3:0]  issue_id_i = 4'd0;
  logic        issue_ready_o;
  logic        issue_accept_o;
  logic        result_valid_o;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_o;

  xif_scheduler #(.MUL_STEPS(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid_i  (issue_valid_i),
    .issue_instr_i  (issue_instr_i),
    .issue_op0_i    (issue_op0_i),
    .issue_op1_i    (issue_op1_i),
    .issue_id_i     (issue_id_i),
    .issue_ready_o  (issue_ready_o),
    .issue_accept_o (issue_accept_o),
    .result_valid_o (result_valid_o),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rinstr(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
                                         logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // Model: a result slot per future cycle, plus the cycle of the multiply in flight
  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  res_t        sched [int];
  bit          seen_reset = 0;
  bit          mul_active = 0;
  int          mul_t = 0;
  logic [3:0]  last_id = 4'd0;
  logic [4:0]  last_rd = 5'd0;
  logic [31:0] last_data = 32'd0;

  initial begin
    bit          m_accept, m_ready, m_is_mul, m_busy, m_valid;
    logic [31:0] prod;
    logic [2:0]  f3;
    forever begin
      @(negedge clk);
      f3       = issue_instr_i[14:12];
      m_is_mul = (f3 == 3'd2);
      m_accept = (issue_instr_i[6:0] == 7'h5B) && (issue_instr_i[31:25] == 7'd0) && (f3 <= 3'd2);
      m_busy   = mul_active && (cyc >= mul_t + 1) && (cyc <= mul_t + 32);
      m_ready  = !(m_busy && ((m_accept && m_is_mul) || (cyc == mul_t + 32)));
      if (seen_reset) begin
        check("accept", {31'd0, issue_accept_o}, {31'd0, m_accept});
        check("ready", {31'd0, issue_ready_o}, {31'd0, m_ready});
        m_valid = sched.exists(cyc);
        if (m_valid) begin
          last_id   = sched[cyc].id;
          last_rd   = sched[cyc].rd;
          last_data = sched[cyc].data;
          sched.delete(cyc);
        end
        check("result_valid", {31'd0, result_valid_o}, {31'd0, m_valid});
        check("result_id", {28'd0, result_id_o}, {28'd0, last_id});
        check("result_rd", {27'd0, result_rd_o}, {27'd0, last_rd});
        check("result_data", result_o, last_data);
      end
      if (reset) begin
        sched.delete();
        mul_active = 0;
        last_id    = 4'd0;
        last_rd    = 5'd0;
        last_data  = 32'd0;
        seen_reset = 1;
      end else if (seen_reset && issue_valid_i && m_ready && m_accept) begin
        if (m_is_mul) begin
          prod = issue_op0_i * issue_op1_i;
          check("slot_free", {31'd0, sched.exists(cyc + 33)}, 32'd0);
          mul_active = 1;
          mul_t      = cyc;
          sched[cyc + 33] = '{issue_id_i, issue_instr_i[11:7], prod};
        end else begin
          prod = (f3 == 3'd1) ? issue_op0_i - issue_op1_i : issue_op0_i + issue_op1_i;
          check("slot_free", {31'd0, sched.exists(cyc + 1)}, 32'd0);
          sched[cyc + 1] = '{issue_id_i, issue_instr_i[11:7], prod};
        end
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] instr, logic [31:0] a, logic [31:0] b,
                       logic [3:0] id);
    issue_valid_i = v;
    issue_instr_i = instr;
    issue_op0_i   = a;
    issue_op1_i   = b;
    issue_id_i    = id;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
  endtask

  // Issue one MUL, then wait (bounded) for its result; returns latency and data
  task automatic run_mul(logic [31:0] a, logic [31:0] b, logic [3:0] id, logic [4:0] rd,
                         output int lat, output logic [31:0] data);
    lat  = -1;
    data = 32'hDEADBEEF;
    next_cycle();
    drive(1'b1, rinstr(7'd0, 3'd2, rd, 7'h5B), a, b, id);
    for (int k = 1; k <= 40; k++) begin
      next_cycle();
      idle();
      #1;
      if (result_valid_o) begin
        lat  = k;
        data = result_o;
        break;
      end
    end
  endtask

  initial begin
    int          lat, low_cnt, low_at, mul_at, acc_at, nres;
    logic [31:0] data;
    logic [31:0] bad [3];

    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, result_valid_o}, 32'd0);
    check("rst_data", result_o, 32'd0);
    check("rst_ready", {31'd0, issue_ready_o}, 32'd1);

    next_cycle();
    drive(1'b1, rinstr(7'd0, 3'd0, 5'd10, 7'h5B), 32'd5, 32'd7, 4'd3);
    next_cycle();
    idle();
    #1;
    check("add_valid", {31'd0, result_valid_o}, 32'd1);
    check("add_data", result_o, 32'd12);
    check("add_id", {28'd0, result_id_o}, 32'd3);
    check("add_rd", {27'd0, result_rd_o}, 32'd10);
    next_cycle();
    check("add_oneshot", {31'd0, result_valid_o}, 32'd0);

    drive(1'b1, rinstr(7'd0, 3'd1, 5'd11, 7'h5B), 32'd5, 32'd7, 4'd9);
    next_cycle();
    idle();
    #1;
    check("sub_data", result_o, 32'hFFFFFFFE);

    run_mul(32'h0000FFFF, 32'h00010001, 4'd1, 5'd5, lat, data);
    check("mul1_latency", lat, 33);
    check("mul1_data", data, 32'hFFFFFFFF);
    run_mul(32'h80000000, 32'd2, 4'd2, 5'd6, lat, data);
    check("mul2_latency", lat, 33);
    check("mul2_data", data, 32'd0);
    run_mul(32'h12345678, 32'h9ABCDEF0, 4'd3, 5'd7, lat, data);
    check("mul3_latency", lat, 33);

    // MUL followed by an ADD every cycle
    low_cnt = 0;
    low_at  = -1;
    mul_at  = -1;
    next_cycle();
    drive(1'b1, rinstr(7'd0, 3'd2, 5'd1, 7'h5B), 32'd3, 32'd4, 4'd4);
    for (int i = 1; i <= 40; i++) begin
      next_cycle();
      drive(1'b1, rinstr(7'd0, 3'd0, 5'd2, 7'h5B), i, 32'd1, 4'(i));
      #1;
      if (!issue_ready_o) begin
        low_cnt++;
        low_at = i;
      end
      if (result_valid_o && result_rd_o == 5'd1) mul_at = i;
    end
    next_cycle();
    idle();
    check("ovl_ready_low_cnt", low_cnt, 1);
    check("ovl_ready_low_at", low_at, 32);
    check("ovl_mul_at", mul_at, 33);

    // Second MUL held while the first is busy
    acc_at = -1;
    next_cycle();
    drive(1'b1, rinstr(7'd0, 3'd2, 5'd3, 7'h5B), 32'd7, 32'd6, 4'd5);
    for (int k = 1; k <= 40; k++) begin
      next_cycle();
      drive(1'b1, rinstr(7'd0, 3'd2, 5'd4, 7'h5B), 32'd9, 32'd9, 4'd6);
      #1;
      if (issue_ready_o) begin
        acc_at = k;
        check("mul_a_data", result_o, 32'd42);
        break;
      end
    end
    check("mul_b_accept_at", acc_at, 33);
    lat  = -1;
    data = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      next_cycle();
      idle();
      #1;
      if (result_valid_o) begin
        lat  = k;
        data = result_o;
        break;
      end
    end
    check("mul_b_latency", lat, 33);
    check("mul_b_data", data, 32'd81);

    bad[0] = rinstr(7'd0, 3'd0, 5'd1, 7'h0B);
    bad[1] = rinstr(7'd0, 3'd3, 5'd1, 7'h5B);
    bad[2] = rinstr(7'd1, 3'd0, 5'd1, 7'h5B);
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      drive(1'b1, bad[j], 32'd1, 32'd2, 4'd8);
      #1;
      check("bad_accept", {31'd0, issue_accept_o}, 32'd0);
      check("bad_ready", {31'd0, issue_ready_o}, 32'd1);
      next_cycle();
      idle();
      #1;
      check("bad_no_result", {31'd0, result_valid_o}, 32'd0);
    end

    // Reset in the middle of a multiply
    nres = 0;
    next_cycle();
    drive(1'b1, rinstr(7'd0, 3'd2, 5'd8, 7'h5B), 32'd100, 32'd200, 4'd7);
    for (int k = 1; k <= 50; k++) begin
      next_cycle();
      idle();
      reset = (k == 10);
      #1;
      if (result_valid_o) nres++;
    end
    reset = 1'b0;
    check("rstmid_no_result", nres, 0);
    check("rstmid_ready", {31'd0, issue_ready_o}, 32'd1);
    next_cycle();
    drive(1'b1, rinstr(7'd0, 3'd0, 5'd12, 7'h5B), 32'd20, 32'd22, 4'd2);
    next_cycle();
    idle();
    #1;
    check("rstmid_add_valid", {31'd0, result_valid_o}, 32'd1);
    check("rstmid_add_data", result_o, 32'd42);

    repeat (4) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
